// File: rtl/xt_hb_arbiter.sv
// Round-robin arbiter that shares the HB slave bus between NUM_MASTER requesters.
// One access at a time: IDLE (arbitrate) -> ACCESS (strobe until finish or timeout) -> RESP (done pulse).
module xt_hb_arbiter #(
  parameter int NUM_MASTER = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                             hb_clk,
  input  logic                             rst_n,
  input  logic [NUM_MASTER-1:0]            req,
  input  logic [NUM_MASTER-1:0]            req_we,
  input  logic [NUM_MASTER*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_MASTER*32-1:0]         req_wdata,
  output logic [NUM_MASTER-1:0]            done,
  output logic [NUM_MASTER-1:0]            err,
  output logic [31:0]                      rdata_out,
  output logic [$clog2(NUM_MASTER)-1:0]    grant_id,
  output logic                             hb_ren,
  output logic                             hb_wen,
  output logic [ADDR_WIDTH-1:0]            hb_raddr,
  output logic [ADDR_WIDTH-1:0]            hb_waddr,
  output logic [31:0]                      hb_wdata,
  input  logic                             read_finish,
  input  logic                             write_finish,
  input  logic [31:0]                      hb_rdata
);

  localparam int IDW = $clog2(NUM_MASTER);
  localparam int CW  = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]            state_reg;
  logic [IDW-1:0]        rr_last_reg;
  logic [IDW-1:0]        grant_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  we_reg;
  logic [NUM_MASTER-1:0] done_reg;
  logic [NUM_MASTER-1:0] err_reg;
  logic [31:0]           rdata_reg;
  logic                  ren_reg;
  logic                  wen_reg;
  logic [ADDR_WIDTH-1:0] raddr_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [31:0]           wdata_reg;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTER];
  logic [31:0]           wdata_arr [NUM_MASTER];

  for (genvar gi = 0; gi < NUM_MASTER; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
  end

  // Walk from lowest to highest priority so the last hit (closest to rr_last+1) wins.
  logic [IDW-1:0] grant_next;
  logic           grant_valid_next;
  int             idx;

  always_comb begin
    grant_next       = '0;
    grant_valid_next = 1'b0;
    idx              = 0;
    for (int i = NUM_MASTER; i >= 1; i--) begin
      idx = int'(rr_last_reg) + i;
      if (idx >= NUM_MASTER) idx = idx - NUM_MASTER;
      if (req[idx]) begin
        grant_next       = IDW'(idx);
        grant_valid_next = 1'b1;
      end
    end
  end

  logic access_finish;
  logic access_timeout;

  assign access_finish  = we_reg ? write_finish : read_finish;
  assign access_timeout = (cnt_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rr_last_reg <= IDW'(NUM_MASTER - 1);
      grant_reg   <= '0;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      done_reg    <= '0;
      err_reg     <= '0;
      rdata_reg   <= '0;
      ren_reg     <= 1'b0;
      wen_reg     <= 1'b0;
      raddr_reg   <= '0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
    end else begin
      done_reg <= '0;
      err_reg  <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_valid_next) begin
            grant_reg   <= grant_next;
            rr_last_reg <= grant_next;
            cnt_reg     <= '0;
            we_reg      <= req_we[grant_next];
            if (req_we[grant_next]) begin
              wen_reg   <= 1'b1;
              waddr_reg <= addr_arr[grant_next];
              wdata_reg <= wdata_arr[grant_next];
            end else begin
              ren_reg   <= 1'b1;
              raddr_reg <= addr_arr[grant_next];
            end
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (access_finish || access_timeout) begin
            ren_reg             <= 1'b0;
            wen_reg             <= 1'b0;
            done_reg[grant_reg] <= 1'b1;
            err_reg[grant_reg]  <= ~access_finish;
            // A timed-out access reports zero data; a completed write leaves rdata untouched.
            if (!access_finish)  rdata_reg <= '0;
            else if (!we_reg)    rdata_reg <= hb_rdata;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign done      = done_reg;
  assign err       = err_reg;
  assign rdata_out = rdata_reg;
  assign grant_id  = grant_reg;
  assign hb_ren    = ren_reg;
  assign hb_wen    = wen_reg;
  assign hb_raddr  = raddr_reg;
  assign hb_waddr  = waddr_reg;
  assign hb_wdata  = wdata_reg;

endmodule

// File: tb/tb_xt_hb_arbiter.sv
// Directed bench for xt_hb_arbiter: single-transaction vector table plus
// contention, mid-access reset and mixed read/write sequences.
module tb_xt_hb_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int TO = 16;

  logic             hb_clk = 1'b0;
  logic             rst_n  = 1'b0;
  logic [NM-1:0]    req = '0;
  logic [NM-1:0]    req_we = '0;
  logic [NM*AW-1:0] req_addr = '0;
  logic [NM*32-1:0] req_wdata = '0;
  logic [NM-1:0]    done;
  logic [NM-1:0]    err;
  logic [31:0]      rdata_out;
  logic [0:0]       grant_id;
  logic             hb_ren;
  logic             hb_wen;
  logic [AW-1:0]    hb_raddr;
  logic [AW-1:0]    hb_waddr;
  logic [31:0]      hb_wdata;
  logic             read_finish;
  logic             write_finish;
  logic [31:0]      hb_rdata;
  logic             dead = 1'b0;

  xt_hb_arbiter #(.NUM_MASTER(NM), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .hb_clk(hb_clk), .rst_n(rst_n),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata_out(rdata_out), .grant_id(grant_id),
    .hb_ren(hb_ren), .hb_wen(hb_wen), .hb_raddr(hb_raddr), .hb_waddr(hb_waddr),
    .hb_wdata(hb_wdata), .read_finish(read_finish), .write_finish(write_finish),
    .hb_rdata(hb_rdata)
  );

  always #5 hb_clk = ~hb_clk;

  // Domain model: small read map, unmapped reads return 0; 'dead' models an unresponsive slave.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'd12:  return 32'hDEADBEEF;
      32'd16:  return 32'h12345678;
      32'd20:  return 32'hCAFEF00D;
      32'd24:  return 32'h0BADF00D;
      default: return 32'h0;
    endcase
  endfunction

  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) read_finish <= 1'b0;
    else        read_finish <= hb_ren && !dead;
  end
  assign write_finish = ~dead;
  assign hb_rdata     = mem_rd(hb_raddr);

  int          ren_cycles  = 0;
  int          wen_cycles  = 0;
  int          overlap     = 0;
  int          done_pulses = 0;
  logic [31:0] last_waddr  = '0;
  logic [31:0] last_wdata  = '0;

  always @(negedge hb_clk) begin
    if (hb_ren) ren_cycles++;
    if (hb_wen) begin
      wen_cycles++;
      last_waddr = hb_waddr;
      last_wdata = hb_wdata;
    end
    if (hb_ren && hb_wen) overlap++;
    if (|done) done_pulses++;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge hb_clk); #1;
      lat++;
      if (done != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge hb_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_master(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    req_we[m]             = we;
    req_addr[m*AW +: AW]  = addr;
    req_wdata[m*32 +: 32] = wdata;
  endtask

  typedef struct {
    int          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          dead;
    int          lat;
    logic [31:0] rdata;
    bit          err;
    int          ren;
    int          wen;
  } vec_t;

  function automatic vec_t mk(input int m, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit dd, input int lat,
                              input logic [31:0] rdata, input bit e, input int ren, input int wen);
    vec_t v;
    v.m = m; v.we = we; v.addr = addr; v.wdata = wdata; v.dead = dd;
    v.lat = lat; v.rdata = rdata; v.err = e; v.ren = ren; v.wen = wen;
    return v;
  endfunction

  vec_t vecs [8];

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          lat;
    bit          ok;
    vec_t        t;
    int          ren0, wen0, dp0;
    logic [31:0] exp_rd [2];

    //           m  we addr        wdata         dead lat rdata         err ren wen
    vecs[0] = mk(0, 0, 32'd12,     32'h0,        0,   3,  32'hDEADBEEF, 0,  2,  0);
    vecs[1] = mk(1, 1, 32'd28,     32'h55,       0,   2,  32'h0,        0,  0,  1);
    vecs[2] = mk(0, 0, 32'd24,     32'h0,        0,   3,  32'h0BADF00D, 0,  2,  0);
    vecs[3] = mk(1, 0, 32'h4000,   32'h0,        0,   3,  32'h0,        0,  2,  0);
    vecs[4] = mk(0, 0, 32'd16,     32'h0,        1,   TO+1, 32'h0,      1,  TO, 0);
    vecs[5] = mk(1, 0, 32'd20,     32'h0,        0,   3,  32'hCAFEF00D, 0,  2,  0);
    vecs[6] = mk(0, 1, 32'd44,     32'h99,       1,   TO+1, 32'h0,      1,  0,  TO);
    vecs[7] = mk(1, 1, 32'h3C,     32'hA5A5A5A5, 0,   2,  32'h0,        0,  0,  1);

    // Reset state
    #2;
    chk("rst_async_done", {30'd0, done}, 32'h0);
    chk("rst_async_ren", {31'd0, hb_ren}, 32'h0);
    do_reset();
    chk("rst_done", {30'd0, done}, 32'h0);
    chk("rst_err", {30'd0, err}, 32'h0);
    chk("rst_rdata", rdata_out, 32'h0);
    chk("rst_grant", {31'd0, grant_id}, 32'h0);
    chk("rst_strobes", {30'd0, hb_ren, hb_wen}, 32'h0);
    chk("rst_addr", hb_raddr | hb_waddr | hb_wdata, 32'h0);

    // Single-transaction vectors
    for (int v = 0; v < 8; v++) begin
      t    = vecs[v];
      ren0 = ren_cycles;
      wen0 = wen_cycles;
      dead = t.dead;
      set_master(t.m, t.we, t.addr, t.wdata);
      req[t.m] = 1'b1;
      wait_done(lat, ok);
      chk($sformatf("v%0d_seen", v), {31'd0, ok}, 32'h1);
      chk($sformatf("v%0d_lat", v), lat, t.lat);
      chk($sformatf("v%0d_done", v), {30'd0, done}, 32'h1 << t.m);
      chk($sformatf("v%0d_err", v), {30'd0, err}, {31'd0, t.err} << t.m);
      chk($sformatf("v%0d_grant", v), {31'd0, grant_id}, t.m);
      if (!t.we) chk($sformatf("v%0d_rdata", v), rdata_out, t.rdata);
      $display("[TB] vec %0d m%0d %s addr=0x%0h lat=%0d done=%b err=%b rdata=0x%0h",
               v, t.m, t.we ? "wr" : "rd", t.addr, lat, done, err, rdata_out);
      req[t.m] = 1'b0;
      dead     = 1'b0;
      @(posedge hb_clk); #1;
      chk($sformatf("v%0d_done_clr", v), {30'd0, done}, 32'h0);
      chk($sformatf("v%0d_ren_cyc", v), ren_cycles - ren0, t.ren);
      chk($sformatf("v%0d_wen_cyc", v), wen_cycles - wen0, t.wen);
      if (t.we && !t.dead) begin
        chk($sformatf("v%0d_waddr", v), last_waddr, t.addr);
        chk($sformatf("v%0d_wdata", v), last_wdata, t.wdata);
      end
    end

    // Contention: both masters read continuously, grants must alternate 0,1,...
    do_reset();
    exp_rd[0] = 32'h12345678;
    exp_rd[1] = 32'hCAFEF00D;
    set_master(0, 0, 32'd16, 32'h0);
    set_master(1, 0, 32'd20, 32'h0);
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_done(lat, ok);
      chk($sformatf("cont%0d_seen", k), {31'd0, ok}, 32'h1);
      chk($sformatf("cont%0d_grant", k), {31'd0, grant_id}, k % 2);
      chk($sformatf("cont%0d_done", k), {30'd0, done}, 32'h1 << (k % 2));
      chk($sformatf("cont%0d_rdata", k), rdata_out, exp_rd[k % 2]);
      $display("[TB] cont %0d grant=%0d done=%b rdata=0x%0h", k, grant_id, done, rdata_out);
    end
    req = 2'b00;
    repeat (2) @(posedge hb_clk);
    #1;

    // Reset in the middle of a read from master 1
    set_master(1, 0, 32'd20, 32'h0);
    req = 2'b10;
    @(posedge hb_clk); #1;
    chk("midrst_ren_before", {31'd0, hb_ren}, 32'h1);
    dp0 = done_pulses;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ren_async", {31'd0, hb_ren}, 32'h0);
    chk("midrst_wen_async", {31'd0, hb_wen}, 32'h0);
    repeat (3) @(posedge hb_clk);
    #1;
    chk("midrst_no_done", done_pulses - dp0, 32'h0);
    set_master(0, 0, 32'd12, 32'h0);
    req   = 2'b11;
    rst_n = 1'b1;
    wait_done(lat, ok);
    chk("midrst_after_grant", {31'd0, grant_id}, 32'h0);
    chk("midrst_after_done", {30'd0, done}, 32'h1);
    chk("midrst_after_rdata", rdata_out, 32'hDEADBEEF);
    $display("[TB] midrst grant=%0d done=%b rdata=0x%0h", grant_id, done, rdata_out);
    req = 2'b00;
    repeat (2) @(posedge hb_clk);
    #1;

    // Mixed: master 0 write and master 1 read pending together
    do_reset();
    set_master(0, 1, 32'd40, 32'h77);
    set_master(1, 0, 32'd12, 32'h0);
    req = 2'b11;
    wait_done(lat, ok);
    chk("mix_wr_lat", lat, 32'd2);
    chk("mix_wr_done", {30'd0, done}, 32'h1);
    chk("mix_wr_waddr", last_waddr, 32'd40);
    chk("mix_wr_wdata", last_wdata, 32'h77);
    $display("[TB] mix wr grant=%0d lat=%0d done=%b", grant_id, lat, done);
    req[0] = 1'b0;
    wait_done(lat, ok);
    chk("mix_rd_seen", {31'd0, ok}, 32'h1);
    chk("mix_rd_done", {30'd0, done}, 32'h2);
    chk("mix_rd_grant", {31'd0, grant_id}, 32'h1);
    chk("mix_rd_rdata", rdata_out, 32'hDEADBEEF);
    $display("[TB] mix rd grant=%0d lat=%0d done=%b rdata=0x%0h", grant_id, lat, done, rdata_out);
    req = 2'b00;
    repeat (2) @(posedge hb_clk);
    #1;
    chk("ren_wen_overlap", overlap, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xt_hb_arbiter.md
Name: xt_hb_arbiter

Overview:
- Round-robin arbiter and access sequencer that shares the HB-domain slave bus between NUM_MASTER requesters (e.g. CPU load/store unit, debug bridge).
- Grants one requester at a time and drives the domain's sel, address and wdata inputs.
- Consumes the domain's read_finish/write_finish handshake, returns read data, and bounds every access with a timeout so a dead slave address cannot hang a requester.

Parameters:
- NUM_MASTER, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, HB address width.
- TIMEOUT, 16, max ACCESS-state cycles before forced completion with error (>=4).

Ports:
- hb_clk  input  1  HB domain clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_MASTER  per-master request level; held until done.
- req_we  input  NUM_MASTER  1=write, 0=read.
- req_addr  input  NUM_MASTER x ADDR_WIDTH  access address.
- req_wdata  input  NUM_MASTER x 32  write data.
- done  output  NUM_MASTER  one-cycle completion pulse, per master.
- err  output  NUM_MASTER  timeout flag; valid only with done.
- rdata_out  output  32  read data; valid with done.
- grant_id  output  $clog2(NUM_MASTER)  index of the current or last granted master.
- hb_ren  output  1  sel.ren to the domain.
- hb_wen  output  1  sel.wen to the domain.
- hb_raddr  output  ADDR_WIDTH  raddr to the domain.
- hb_waddr  output  ADDR_WIDTH  waddr to the domain.
- hb_wdata  output  32  write data to the domain.
- read_finish  input  1  from the domain; registered, high one cycle after ren.
- write_finish  input  1  from the domain; may be tied to 1.
- hb_rdata  input  32  domain read mux output.

Behaviour:
- Reset: asynchronous, active-low.
  - State=IDLE; all outputs 0; rr_last=NUM_MASTER-1, so master 0 has first priority; timeout counter 0.
  - Reset mid-access aborts immediately: no done pulse, hb_ren and hb_wen drop asynchronously.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples req. If any bit is set, grants the first requesting index searching upward from rr_last+1 (mod NUM_MASTER).
  - On grant, latches that master's we/addr/wdata, updates grant_id and rr_last, clears the counter, and moves to ACCESS.
  - req is sampled only in IDLE.
- ACCESS, read:
  - hb_ren=1; hb_raddr=latched addr; hb_wen=0.
  - Each cycle: if read_finish=1, capture hb_rdata and go to RESP. Otherwise increment the counter.
- ACCESS, write:
  - hb_wen=1 for exactly one cycle per ACCESS cycle; hb_waddr and hb_wdata latched.
  - If write_finish=1, go to RESP. With write_finish tied to 1, ACCESS lasts one cycle, so there is a single write strobe.
- Timeout: in ACCESS, if the counter reaches TIMEOUT-1 with no finish, go to RESP with err set and rdata_out=0.
- RESP:
  - done[grant_id]=1 for one cycle; err[grant_id] set as determined; rdata_out set for reads and held until the next RESP.
  - hb_ren=hb_wen=0.
  - Next state is IDLE.
- Latency (req rise to done, finish signals behaving as the domain produces them):
  - Read: 3 cycles (IDLE → ACCESS ×2 → RESP).
  - Write: 2 cycles (IDLE → ACCESS ×1 → RESP).
- Requester rule: deassert req on the edge where done is observed unless issuing a new request. A req still high in the following IDLE is treated as a new request.
- A back-to-back master competes normally through round-robin.
- Fairness: with all requests continuously high, grants rotate 0,1,…,N-1,0. No master waits more than NUM_MASTER-1 accesses.
- Read and write are never asserted together.
- Addresses are passed through unchanged; slave decode belongs to the domain.
- An unmapped address returns whatever the domain returns (0) with err=0.
- err=1 only on timeout.
- Counter width: $clog2(TIMEOUT). Saturation is not required because RESP exits first.

Test Plan:
- Reset then single read: master 0 reads addr 12, domain returns 0xDEADBEEF → hb_ren high 2 cycles; done[0] 3 cycles after req; rdata_out=0xDEADBEEF; err[0]=0.
- Single write: master 1 writes 0x55 to addr 28, write_finish=1 → exactly one hb_wen cycle with hb_waddr=28, hb_wdata=0x55; done[1] 2 cycles after req.
- Contention: both masters request reads continuously for 6 accesses → grant order 0,1,0,1,0,1; each done carries the matching rdata.
- Timeout: read_finish held 0, TIMEOUT=16 → done with err=1 and rdata_out=0 after 16 ACCESS cycles; next request is served normally.
- Reset mid-read: rst_n low during ACCESS → hb_ren=0 immediately, no done pulse; after release, master 0 has priority.
- Mixed ops: master 0 writes while master 1 reads pending → write completes first, then read; hb_ren and hb_wen never high together.
